n64_pi_master: RTL and testbench

- Initiator side of the N64 parallel-interface (PI) cartridge bus: generates the ALEH/ALEL address phases and READ_n strobes that the cart-side responder (N64DevCartMain) answers.
- Used as an on-board bench driver and loopback checker for the dev cart ROM path, and as the engine for dumping a foreign cart.
- Accepts a burst-read command (byte address, halfword count) and returns each 16-bit halfword on a valid/ready stream.

---
 rtl/n64_pi_master.sv | 183 ++++++++++++++++++
 tb/tb_n64_pi_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_pi_master.sv
// n64_pi_master: initiator for the N64 parallel-interface cart bus.
// Drives the ALEH/ALEL address phases and READ_n strobes for a burst read.
// Each sampled halfword comes back on a single-entry valid/ready response register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a command, cmdReady high
// S_ADDR_HI | aleh=alel=1, AD drives addr[31:16] for T_ALE cycles
// S_ADDR_LO | alel=1, AD drives addr[15:0] for T_ALE cycles
// S_ALE_END | alel falls, AD still driven for one cycle
// S_LAT     | AD released, cart access latency of T_LAT cycles
// S_RD_LO   | READ_n low for T_RDL cycles, AD sampled on the last one
// S_RD_HI   | READ_n high for at least T_RDH cycles, stretched by backpressure
// S_FIN     | one-cycle done pulse, last response already accepted
module n64_pi_master #(
  parameter int T_ALE = 4,
  parameter int T_LAT = 8,
  parameter int T_RDL = 6,
  parameter int T_RDH = 4,
  parameter int LEN_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_cmdValid,
  output logic             io_cmdReady,
  input  logic [31:0]      io_cmdAddr,
  input  logic [LEN_W-1:0] io_cmdLen,
  output logic             io_rspValid,
  input  logic             io_rspReady,
  output logic [15:0]      io_rspData,
  output logic             io_rspLast,
  output logic             io_busy,
  output logic             io_done,
  output logic [15:0]      io_adOut,
  output logic             io_adOe,
  input  logic [15:0]      io_adIn,
  output logic             io_aleh,
  output logic             io_alel,
  output logic             io_readn
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_ALE_END, S_LAT, S_RD_LO, S_RD_HI, S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic               rsp_last_q, rsp_last_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        ad_out_q, ad_out_d;
  logic               ad_oe_q, ad_oe_d;
  logic               aleh_q, aleh_d;
  logic               alel_q, alel_d;
  logic               readn_q, readn_d;
  logic               cnt_done;
  logic               rsp_free;

  // Phase length minus one, loaded into the down-counter on state entry.
  function automatic logic [7:0] phase_len(input state_t s);
    case (s)
      S_ADDR_HI, S_ADDR_LO: phase_len = 8'(T_ALE - 1);
      S_LAT:                phase_len = 8'(T_LAT - 1);
      S_RD_LO:              phase_len = 8'(T_RDL - 1);
      S_RD_HI:              phase_len = 8'(T_RDH - 1);
      default:              phase_len = 8'd0;
    endcase
  endfunction

  // State, datapath and registered bus outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      aleh_q      <= 1'b0;
      alel_q      <= 1'b0;
      readn_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      aleh_q      <= aleh_d;
      alel_q      <= alel_d;
      readn_q     <= readn_d;
    end
  end

  // Next state, phase timer, command capture and response register.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    rsp_valid_d = rsp_valid_q && !io_rspReady;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    cnt_done    = (cnt_q == 8'd0);
    rsp_free    = !rsp_valid_q || io_rspReady;
    unique case (state_q)
      S_IDLE: begin
        if (io_cmdValid && cmd_ready_q) begin
          state_d = S_ADDR_HI;
          addr_d  = io_cmdAddr & 32'hFFFF_FFFE;
          rem_d   = io_cmdLen;
        end
      end
      S_ADDR_HI: if (cnt_done) state_d = S_ADDR_LO;
      S_ADDR_LO: if (cnt_done) state_d = S_ALE_END;
      S_ALE_END: state_d = S_LAT;
      S_LAT: begin
        if (cnt_done) state_d = (rem_q == '0) ? S_FIN : S_RD_LO;
      end
      S_RD_LO: begin
        if (cnt_done) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = io_adIn;
          rsp_last_d  = (rem_q == LEN_W'(1));
          rem_d       = rem_q - LEN_W'(1);
          state_d     = S_RD_HI;
        end
      end
      S_RD_HI: begin
        // READ_n stays high until the response slot can take the next sample.
        if (cnt_done && rsp_free) state_d = (rem_q == '0) ? S_FIN : S_RD_LO;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = phase_len(state_d);
    else if (!cnt_done)     cnt_d = cnt_q - 8'd1;
    else                    cnt_d = cnt_q;
  end

  // Bus strobes decoded from the next state so the pins change with the state.
  always_comb begin
    aleh_d      = (state_d == S_ADDR_HI);
    alel_d      = (state_d == S_ADDR_HI) || (state_d == S_ADDR_LO);
    ad_oe_d     = alel_d || (state_d == S_ALE_END);
    readn_d     = (state_d != S_RD_LO);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    cmd_ready_d = (state_d == S_IDLE);
    ad_out_d    = ad_out_q;
    if (state_d == S_ADDR_HI)      ad_out_d = addr_d[31:16];
    else if (state_d == S_ADDR_LO) ad_out_d = addr_d[15:0];
  end

  assign io_cmdReady = cmd_ready_q;
  assign io_rspValid = rsp_valid_q;
  assign io_rspData  = rsp_data_q;
  assign io_rspLast  = rsp_last_q;
  assign io_busy     = busy_q;
  assign io_done     = done_q;
  assign io_adOut    = ad_out_q;
  assign io_adOe     = ad_oe_q;
  assign io_aleh     = aleh_q;
  assign io_alel     = alel_q;
  assign io_readn    = readn_q;

endmodule

// File: tb/tb_n64_pi_master.sv
// tb_n64_pi_master: cart ROM responder plus response scoreboard for n64_pi_master.
module tb_n64_pi_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_cmdValid = 1'b0;
  logic        io_cmdReady;
  logic [31:0] io_cmdAddr = '0;
  logic [8:0]  io_cmdLen = '0;
  logic        io_rspValid;
  logic        io_rspReady = 1'b1;
  logic [15:0] io_rspData;
  logic        io_rspLast;
  logic        io_busy;
  logic        io_done;
  logic [15:0] io_adOut;
  logic        io_adOe;
  logic [15:0] io_adIn = '0;
  logic        io_aleh;
  logic        io_alel;
  logic        io_readn;

  n64_pi_master dut (
    .clock(clock), .reset(reset),
    .io_cmdValid(io_cmdValid), .io_cmdReady(io_cmdReady),
    .io_cmdAddr(io_cmdAddr), .io_cmdLen(io_cmdLen),
    .io_rspValid(io_rspValid), .io_rspReady(io_rspReady),
    .io_rspData(io_rspData), .io_rspLast(io_rspLast),
    .io_busy(io_busy), .io_done(io_done),
    .io_adOut(io_adOut), .io_adOe(io_adOe), .io_adIn(io_adIn),
    .io_aleh(io_aleh), .io_alel(io_alel), .io_readn(io_readn)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Owned by the main process.
  logic [15:0] rom[$];
  logic [31:0] rom_base = '0;
  logic [16:0] exp_q[$];
  int acc_cyc, b_fall, b_low, b_aleh, b_alel, b_done, b_valid;

  // Owned by the monitor.
  int          cyc = 0;
  int          rd_idx = 0;
  logic [15:0] lat_hi = '0, lat_lo = '0;
  logic [31:0] cur_addr = '0;
  logic        prev_readn = 1'b1;
  int          low_len = 0;
  int          falls[$];
  int          lows[$];
  int          aleh_cnt = 0, alel_cnt = 0, done_cnt = 0, valid_cnt = 0;

  function automatic logic [15:0] rom_word(input logic [31:0] a);
    int idx;
    idx = int'((a - rom_base) >> 1);
    if (a >= rom_base && idx < rom.size()) return rom[idx];
    return 16'hDEAD;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Cart responder and response scoreboard, sampled on the falling edge.
  always @(negedge clock) begin
    logic [16:0] e;
    if (!reset) begin
      prev_readn = 1'b1;
      rd_idx     = exp_q.size();
      io_adIn    = 16'($urandom);
    end else begin
      if (io_aleh && io_alel) begin
        lat_hi = io_adOut;
        aleh_cnt++;
      end else if (io_alel) begin
        lat_lo   = io_adOut;
        alel_cnt++;
        cur_addr = {lat_hi, io_adOut};
      end
      if (!io_readn) begin
        if (prev_readn) begin
          falls.push_back(cyc);
          low_len = 0;
        end
        low_len++;
        io_adIn = rom_word(cur_addr);
      end else if (!prev_readn) begin
        lows.push_back(low_len);
        cur_addr = cur_addr + 32'd2;
        io_adIn  = 16'h5A5A;
      end
      prev_readn = io_readn;
      if (io_done) done_cnt++;
      if (io_rspValid) valid_cnt++;
      if (io_rspValid && io_rspReady) begin
        if (rd_idx >= exp_q.size()) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q[rd_idx];
          rd_idx++;
          check("rsp_data", 32'(io_rspData), 32'(e[15:0]));
          check("rsp_last", 32'(io_rspLast), 32'(e[16]));
        end
      end
    end
  end

  task automatic start_cmd(input logic [31:0] addr, input int len);
    bit ok;
    rom_base = addr & 32'hFFFF_FFFE;
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, rom[i]});
    b_fall = falls.size(); b_low = lows.size(); b_aleh = aleh_cnt; b_alel = alel_cnt;
    b_done = done_cnt; b_valid = valid_cnt;
    @(posedge clock); #1;
    io_cmdValid = 1'b1; io_cmdAddr = addr; io_cmdLen = 9'(len);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (io_cmdReady) begin ok = 1'b1; break; end
    end
    check("cmd_ready_wait", 32'(ok), 32'd1);
    @(posedge clock); #1;
    acc_cyc = cyc;
    io_cmdValid = 1'b0; io_cmdAddr = $urandom;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done_cnt > b_done) begin ok = 1'b1; break; end
    end
    check("done_timeout", 32'(ok), 32'd1);
    @(negedge clock);
    check("idle_busy", 32'(io_busy), 32'd0);
    check("idle_cmd_ready", 32'(io_cmdReady), 32'd1);
    check("done_pulses", 32'(done_cnt - b_done), 32'd1);
    check("sb_drained", 32'(exp_q.size() - rd_idx), 32'd0);
  endtask

  initial begin
    logic [15:0] first;
    bit ok, stable;

    // Reset with random inputs
    repeat (5) begin
      @(posedge clock); #1;
      io_cmdValid = 1'($urandom); io_rspReady = 1'($urandom);
      io_cmdAddr = $urandom; io_cmdLen = 9'($urandom);
    end
    @(negedge clock);
    check("rst_readn", 32'(io_readn), 32'd1);
    check("rst_aleh", 32'(io_aleh), 32'd0);
    check("rst_alel", 32'(io_alel), 32'd0);
    check("rst_adoe", 32'(io_adOe), 32'd0);
    check("rst_rspvalid", 32'(io_rspValid), 32'd0);
    check("rst_cmdready", 32'(io_cmdReady), 32'd0);
    check("rst_busy", 32'(io_busy), 32'd0);
    io_cmdValid = 1'b0; io_rspReady = 1'b1;
    @(posedge clock); #3;
    reset = 1'b1;
    @(negedge clock);
    check("rel_cmdready_0", 32'(io_cmdReady), 32'd0);
    @(negedge clock);
    check("rel_cmdready_1", 32'(io_cmdReady), 32'd1);

    // Single read
    rom = '{16'h8037};
    start_cmd(32'h1000_0040, 1);
    wait_done(300);
    check("s_addr_hi", 32'(lat_hi), 32'h1000);
    check("s_addr_lo", 32'(lat_lo), 32'h0040);
    check("s_aleh_cycles", 32'(aleh_cnt - b_aleh), 32'd4);
    check("s_alel_lo_cycles", 32'(alel_cnt - b_alel), 32'd4);
    check("s_pulses", 32'(falls.size() - b_fall), 32'd1);
    if (falls.size() > b_fall) check("s_first_fall", 32'(falls[b_fall] - acc_cyc), 32'd17);
    if (lows.size() > b_low) check("s_low_len", 32'(lows[b_low]), 32'd6);

    // Burst of 4 against ROM contents
    rom = '{16'h8037, 16'h1240, 16'h0000, 16'h000F};
    start_cmd(32'h1000_0000, 4);
    wait_done(500);
    check("b_pulses", 32'(falls.size() - b_fall), 32'd4);
    check("b_valid_cycles", 32'(valid_cnt - b_valid), 32'd4);
    for (int i = 1; i < 4; i++)
      if (falls.size() > b_fall + i)
        check("b_spacing", 32'(falls[b_fall + i] - falls[b_fall + i - 1]), 32'd10);

    // Backpressure
    rom = '{16'hA001, 16'hB002, 16'hC003};
    @(posedge clock); #1;
    io_rspReady = 1'b0;
    start_cmd(32'h1000_0100, 3);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (io_rspValid) begin ok = 1'b1; break; end
    end
    check("bp_first_valid", 32'(ok), 32'd1);
    first = io_rspData;
    stable = 1'b1;
    b_low = falls.size();
    repeat (20) begin
      @(negedge clock);
      if (io_rspData !== first || io_rspValid !== 1'b1 || io_rspLast !== 1'b0 || io_readn !== 1'b1)
        stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_held_data", 32'(first), 32'hA001);
    check("bp_no_pulse", 32'(falls.size() - b_low), 32'd0);
    @(posedge clock); #1;
    io_rspReady = 1'b1;
    wait_done(500);
    check("bp_pulses", 32'(falls.size() - b_fall), 32'd3);

    // Zero length with odd address
    rom.delete();
    start_cmd(32'h1000_0001, 0);
    wait_done(300);
    check("z_addr_hi", 32'(lat_hi), 32'h1000);
    check("z_addr_lo", 32'(lat_lo), 32'h0000);
    check("z_pulses", 32'(falls.size() - b_fall), 32'd0);
    check("z_valid", 32'(valid_cnt - b_valid), 32'd0);

    // Async reset during the 2nd RD_LO of a len=8 burst
    rom = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707, 16'h0808};
    start_cmd(32'h1000_0200, 8);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (falls.size() - b_fall == 2 && !io_readn) begin ok = 1'b1; break; end
    end
    check("ar_reach_rd2", 32'(ok), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar_readn", 32'(io_readn), 32'd1);
    check("ar_aleh", 32'(io_aleh), 32'd0);
    check("ar_alel", 32'(io_alel), 32'd0);
    check("ar_adoe", 32'(io_adOe), 32'd0);
    check("ar_adout", 32'(io_adOut), 32'd0);
    check("ar_rspvalid", 32'(io_rspValid), 32'd0);
    check("ar_busy", 32'(io_busy), 32'd0);
    check("ar_cmdready", 32'(io_cmdReady), 32'd0);
    b_fall = falls.size();
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    check("ar_no_pulse", 32'(falls.size() - b_fall), 32'd0);

    // Clean command after reset
    rom = '{16'h1111, 16'h2222};
    start_cmd(32'h1000_0300, 2);
    wait_done(400);
    check("pr_addr_lo", 32'(lat_lo), 32'h0300);
    check("pr_pulses", 32'(falls.size() - b_fall), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
